// File: rtl/cond_logic_pipe_if.sv
// Bundle of the decoder/ALU controls into the condition unit and the gated enables back out.
// The master side drives instructions; the slave side is the condition unit.
interface cond_logic_pipe_if #(
  parameter int IT_DEPTH = 4,
  parameter int CW       = $clog2(IT_DEPTH + 1)
);
  logic                Stall;
  logic                Flush;
  logic [3:0]          Cond;
  logic [3:0]          ALUFlags;
  logic [1:0]          FlagW;
  logic                PCS;
  logic                RegW;
  logic                MemW;
  logic                NoWrite;
  logic                ItStart;
  logic [CW-1:0]       ItLen;
  logic [IT_DEPTH-1:0] ItMask;
  logic [3:0]          ItCond;
  logic                PCSrc;
  logic                RegWrite;
  logic                MemWrite;
  logic                CondEx;
  logic [3:0]          Flags;
  logic                ItActive;
  logic                ItErr;

  modport master (
    output Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           ItStart, ItLen, ItMask, ItCond,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ItActive, ItErr
  );

  modport slave (
    input  Stall, Flush, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
           ItStart, ItLen, ItMask, ItCond,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, ItActive, ItErr
  );
endinterface

// File: rtl/cond_logic_pipe.sv
// Condition-code unit: evaluates instruction/IT-block conditions against the
// architectural flags, gates write enables and tracks predicated blocks.
module cond_logic_pipe #(
  parameter int IT_DEPTH = 4,
  parameter int PIPE     = 1
) (
  input  logic               clk,
  input  logic               reset,
  cond_logic_pipe_if.slave   bus
);
  localparam int CW = $clog2(IT_DEPTH + 1);
  localparam int SW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;

  typedef enum logic {IDLE, ACTIVE} st_t;

  st_t                 state, state_nx;
  logic [SW-1:0]       slot, slot_nx;
  logic [CW-1:0]       rem, rem_nx;
  logic [3:0]          it_cond;
  logic [IT_DEPTH-1:0] it_mask;
  logic [3:0]          flags;
  logic                load;

  logic                active, live, cond_ex, wr_ok;
  logic                reg_we, mem_we, pc_src, it_err;
  logic [3:0]          eff;
  logic [CW-1:0]       len_c;

  function automatic logic eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Inside a block, an else slot runs the base condition with its low bit flipped.
  always_comb begin
    active  = (state == ACTIVE);
    eff     = active ? (it_mask[slot] ? it_cond : {it_cond[3:1], ~it_cond[0]}) : bus.Cond;
    live    = ~bus.Stall & ~bus.Flush;
    cond_ex = eval(eff, flags) & live;
    wr_ok   = cond_ex & ~bus.ItStart;
    reg_we  = bus.RegW & wr_ok & ~bus.NoWrite;
    mem_we  = bus.MemW & wr_ok;
    pc_src  = bus.PCS & wr_ok;
    it_err  = active & bus.ItStart & live;
    len_c   = (bus.ItLen > CW'(IT_DEPTH)) ? CW'(IT_DEPTH) : bus.ItLen;
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    rem_nx   = rem;
    load     = 1'b0;
    if (bus.Flush) begin
      state_nx = IDLE;
      slot_nx  = '0;
      rem_nx   = '0;
    end else if (!bus.Stall) begin
      case (state)
        IDLE: begin
          if (bus.ItStart && cond_ex && bus.ItLen != '0) begin
            state_nx = ACTIVE;
            slot_nx  = '0;
            rem_nx   = len_c;
            load     = 1'b1;
          end
        end
        ACTIVE: begin
          // A taken branch leaves the block at the same edge as the last slot would.
          if (pc_src || rem <= CW'(1)) begin
            state_nx = IDLE;
            slot_nx  = '0;
            rem_nx   = '0;
          end else begin
            slot_nx  = slot + SW'(1);
            rem_nx   = rem - CW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      slot    <= '0;
      rem     <= '0;
      it_cond <= '0;
      it_mask <= '0;
      flags   <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      rem   <= rem_nx;
      if (load) begin
        it_cond <= bus.ItCond;
        it_mask <= bus.ItMask;
      end
      if (bus.FlagW[1] & cond_ex) flags[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0] & cond_ex) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign bus.Flags    = flags;
  assign bus.ItActive = active;

  generate
    if (PIPE != 0) begin : g_reg
      logic [4:0] o_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) o_q <= '0;
        else        o_q <= {pc_src, reg_we, mem_we, cond_ex, it_err};
      end
      assign {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx, bus.ItErr} = o_q;
    end else begin : g_comb
      assign {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.CondEx, bus.ItErr} =
             {pc_src, reg_we, mem_we, cond_ex, it_err};
    end
  endgenerate
endmodule

// File: tb/tb_cond_logic_pipe.sv
// Drives a PIPE=1 and a PIPE=0 instance with the same instruction stream and
// scoreboards both against a queue-based model of the predicated-block rules.
module tb_cond_logic_pipe;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cond_logic_pipe_if #(.IT_DEPTH(D)) b1 ();
  cond_logic_pipe_if #(.IT_DEPTH(D)) b0 ();

  cond_logic_pipe #(.IT_DEPTH(D), .PIPE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  cond_logic_pipe #(.IT_DEPTH(D), .PIPE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

  typedef struct {
    logic st, fl;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic pcs, regw, memw, nowr, its;
    logic [CW-1:0] len;
    logic [D-1:0] mask;
    logic [3:0] itc;
  } stim_t;

  typedef struct {
    logic pcsrc, regwr, memwr, condex, iterr, itact;
    logic [3:0] flags;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] m_flags = '0;
  logic [3:0] blk[$];
  logic mon_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Even codes name a base test; the odd partner is its complement.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // The block is a queue of effective conditions, one per remaining slot.
  task automatic model_step(input stim_t s, output exp_t e);
    logic act, live, pass, ok;
    logic [3:0] eff;
    int n;
    act  = (blk.size() != 0);
    eff  = act ? blk[0] : s.cond;
    live = !s.st && !s.fl;
    pass = cond_ok(eff, m_flags) && live;
    ok   = pass && !s.its;
    e.condex = pass;
    e.regwr  = s.regw && ok && !s.nowr;
    e.memwr  = s.memw && ok;
    e.pcsrc  = s.pcs && ok;
    e.iterr  = act && s.its && live;
    e.itact  = act;
    e.flags  = m_flags;
    if (s.fl) blk.delete();
    else if (live) begin
      if (pass && s.fw[1]) m_flags[3:2] = s.alu[3:2];
      if (pass && s.fw[0]) m_flags[1:0] = s.alu[1:0];
      if (act) begin
        void'(blk.pop_front());
        if (e.pcsrc) blk.delete();
      end else if (s.its && pass && s.len != 0) begin
        n = (int'(s.len) > D) ? D : int'(s.len);
        for (int i = 0; i < n; i++)
          blk.push_back(s.mask[i] ? s.itc : {s.itc[3:1], ~s.itc[0]});
      end
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.st = 0; s.fl = 0; s.cond = 4'hE; s.alu = 0; s.fw = 0;
    s.pcs = 0; s.regw = 0; s.memw = 0; s.nowr = 0; s.its = 0;
    s.len = 0; s.mask = 0; s.itc = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    {b1.Stall, b1.Flush, b1.Cond, b1.ALUFlags, b1.FlagW} = {s.st, s.fl, s.cond, s.alu, s.fw};
    {b1.PCS, b1.RegW, b1.MemW, b1.NoWrite, b1.ItStart} = {s.pcs, s.regw, s.memw, s.nowr, s.its};
    {b1.ItLen, b1.ItMask, b1.ItCond} = {s.len, s.mask, s.itc};
    {b0.Stall, b0.Flush, b0.Cond, b0.ALUFlags, b0.FlagW} = {s.st, s.fl, s.cond, s.alu, s.fw};
    {b0.PCS, b0.RegW, b0.MemW, b0.NoWrite, b0.ItStart} = {s.pcs, s.regw, s.memw, s.nowr, s.its};
    {b0.ItLen, b0.ItMask, b0.ItCond} = {s.len, s.mask, s.itc};
    model_step(s, e);
    q0.push_back(e);
    q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [3:0] c, input logic regw);
    stim_t s;
    s = nop(); s.cond = c; s.regw = regw;
    apply(s);
  endtask

  task automatic it_open(input logic [CW-1:0] len, input logic [D-1:0] mask, input logic [3:0] itc);
    stim_t s;
    s = nop(); s.its = 1; s.len = len; s.mask = mask; s.itc = itc; s.regw = 1;
    apply(s);
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, " p1 enables"}, {b1.PCSrc, b1.RegWrite, b1.MemWrite, b1.CondEx}, 4'h0);
    cmp({tag, " p0 Flags"}, b0.Flags, 4'h0);
    cmp({tag, " p1 Flags"}, b1.Flags, 4'h0);
    cmp({tag, " ItActive/ItErr"}, {b0.ItActive, b1.ItActive, b1.ItErr, 1'b0}, 4'h0);
  endtask

  // Combinational instance is checked in the issue cycle, registered one a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("p0 PCSrc", b0.PCSrc, e.pcsrc);
        cmp("p0 RegWrite", b0.RegWrite, e.regwr);
        cmp("p0 MemWrite", b0.MemWrite, e.memwr);
        cmp("p0 CondEx", b0.CondEx, e.condex);
        cmp("p0 ItErr", b0.ItErr, e.iterr);
        cmp("p0 Flags", b0.Flags, e.flags);
        cmp("p0 ItActive", b0.ItActive, e.itact);
        cmp("p1 Flags", b1.Flags, e.flags);
        cmp("p1 ItActive", b1.ItActive, e.itact);
      end
      if (q1.size() >= 2) begin
        e = q1.pop_front();
        cmp("p1 PCSrc", b1.PCSrc, e.pcsrc);
        cmp("p1 RegWrite", b1.RegWrite, e.regwr);
        cmp("p1 MemWrite", b1.MemWrite, e.memwr);
        cmp("p1 CondEx", b1.CondEx, e.condex);
        cmp("p1 ItErr", b1.ItErr, e.iterr);
      end
    end
  end

  initial begin
    stim_t s;
    apply_inputs_idle();
    #12;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    ins(4'h0, 1);                              // EQ against reset flags: no enable
    s = nop(); s.fw = 2'b11; s.alu = 4'b0100; apply(s);
    ins(4'h0, 1);                              // EQ with Z=1
    s = nop(); s.cond = 4'h0; s.regw = 1; s.nowr = 1; apply(s);
    ins(4'h1, 1);                              // NE fails
    s = nop(); s.fw = 2'b10; s.alu = 4'hF; apply(s);
    s = nop(); s.fw = 2'b01; s.alu = 4'hF; s.cond = 4'hF; apply(s);
    ins(4'hE, 0);

    it_open(3'd3, 4'b0101, 4'h0);              // then/else/then
    repeat (3) ins(4'hE, 1);
    ins(4'hE, 1);

    it_open(3'd3, 4'b0101, 4'h0);              // stall on slot 1
    ins(4'hE, 1);
    s = nop(); s.st = 1; s.regw = 1; apply(s);
    repeat (2) ins(4'hE, 1);
    ins(4'hF, 1);

    it_open(3'd3, 4'b0111, 4'h0);              // flush on slot 1
    ins(4'hE, 1);
    s = nop(); s.fl = 1; s.regw = 1; apply(s);
    ins(4'hE, 1);

    it_open(3'd2, 4'b0011, 4'h0);              // nested open in slot 0
    it_open(3'd4, 4'b1111, 4'hE);
    repeat (2) ins(4'hE, 1);

    it_open(3'd4, 4'b1111, 4'hE);              // branch out in slot 0
    s = nop(); s.pcs = 1; s.memw = 1; apply(s);
    ins(4'hF, 1);

    it_open(3'd7, 4'b1111, 4'hE);              // length saturates at IT_DEPTH
    repeat (5) ins(4'hF, 1);

    it_open(3'd0, 4'b1111, 4'hE);              // zero length opens nothing
    ins(4'hF, 1);

    it_open(3'd3, 4'b1111, 4'hE);              // reset inside a block
    ins(4'hF, 1);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid-block reset");
    q0.delete(); q1.delete(); blk.delete(); m_flags = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    ins(4'hF, 1);                              // a surviving block would pass AL here
    ins(4'h0, 1);

    for (int k = 0; k < 600; k++) begin
      s.st   = ($urandom_range(7) == 0);
      s.fl   = ($urandom_range(15) == 0);
      s.cond = 4'($urandom_range(15));
      s.alu  = 4'($urandom_range(15));
      s.pcs  = ($urandom_range(5) == 0);
      s.regw = 1'($urandom_range(1));
      s.memw = 1'($urandom_range(1));
      s.nowr = ($urandom_range(3) == 0);
      s.its  = ($urandom_range(4) == 0);
      s.fw   = s.its ? 2'b00 : 2'($urandom_range(3));
      s.len  = CW'($urandom_range(7));
      s.mask = D'($urandom_range(15));
      s.itc  = 4'($urandom_range(15));
      apply(s);
    end

    apply(nop());
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic apply_inputs_idle();
    stim_t s;
    s = nop();
    {b1.Stall, b1.Flush, b1.Cond, b1.ALUFlags, b1.FlagW} = {s.st, s.fl, s.cond, s.alu, s.fw};
    {b1.PCS, b1.RegW, b1.MemW, b1.NoWrite, b1.ItStart} = {s.pcs, s.regw, s.memw, s.nowr, s.its};
    {b1.ItLen, b1.ItMask, b1.ItCond} = {s.len, s.mask, s.itc};
    {b0.Stall, b0.Flush, b0.Cond, b0.ALUFlags, b0.FlagW} = {s.st, s.fl, s.cond, s.alu, s.fw};
    {b0.PCS, b0.RegW, b0.MemW, b0.NoWrite, b0.ItStart} = {s.pcs, s.regw, s.memw, s.nowr, s.its};
    {b0.ItLen, b0.ItMask, b0.ItCond} = {s.len, s.mask, s.itc};
  endtask
endmodule

// File: doc/cond_logic_pipe.md
COND_LOGIC_PIPE -- requirements
Module: cond_logic_pipe

Interface
REQ-001 The block SHALL have parameter IT_DEPTH, default 4, giving the maximum predicated-block length (range 1..8).
REQ-002 The block SHALL have parameter PIPE, default 1: 1 = outputs registered, 0 = outputs combinational.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-004 The block SHALL have the following ports, listed as name, direction, width, meaning:
  - clk  in  1  clock.
  - reset  in  1  async active-low reset.
  - Stall  in  1  hold all state; current instruction becomes a bubble.
  - Flush  in  1  kill current instruction; clear the IT state.
  - Cond  in  4  instruction condition code.
  - ALUFlags  in  4  {N,Z,C,V} from the ALU.
  - FlagW  in  2  [1] = write N,Z; [0] = write C,V.
  - PCS, RegW, MemW, NoWrite  in  1 each  decoder controls.
  - ItStart  in  1  current instruction opens a predicated block.
  - ItLen  in  CW  block length (1..IT_DEPTH); CW = clog2(IT_DEPTH+1).
  - ItMask  in  IT_DEPTH  bit i = 1 means then, 0 means else, for block slot i.
  - ItCond  in  4  block base condition.
  - PCSrc, RegWrite, MemWrite  out  1 each  gated enables.
  - CondEx  out  1  condition passed.
  - Flags  out  4  architectural {N,Z,C,V}.
  - ItActive  out  1  the block is in state ACTIVE.
  - ItErr  out  1  one-cycle pulse for a nested ItStart.

Function
REQ-005 Condition evaluation SHALL use the registered Flags, with N=Flags[3], Z=[2], C=[1], V=[0]:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V.
  - GT ~Z&(N==V); LE Z|(N!=V); 1110 = 1; 1111 = 0.
REQ-006 The effective condition SHALL be Cond in state IDLE, and in state ACTIVE SHALL be ItCond when ItMask[slot]=1, or {ItCond[3:1],~ItCond[0]} when ItMask[slot]=0.
REQ-007 The enables SHALL be CondEx = eval(effective condition) & ~Stall & ~Flush.
REQ-008 The output gating SHALL be:
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
  - PCSrc = PCS & CondEx.
REQ-009 When the block is in state IDLE and ItStart=1, RegWrite, MemWrite and PCSrc SHALL be forced to 0.
REQ-010 Flags[3:2] SHALL load ALUFlags[3:2] on a rising edge when FlagW[1]&CondEx, and Flags[1:0] SHALL load ALUFlags[1:0] when FlagW[0]&CondEx; otherwise Flags SHALL hold.
REQ-011 Flag writes SHALL become visible to the condition evaluation of the next instruction.
REQ-012 The IT state machine SHALL have states IDLE and ACTIVE, with a slot counter slot (0..IT_DEPTH-1) and a remaining counter rem (0..IT_DEPTH).
REQ-013 IDLE -> ACTIVE SHALL occur on ItStart & ~Stall & ~Flush & eval(Cond) & ItLen!=0, loading rem=min(ItLen,IT_DEPTH), slot=0, and latching ItCond and ItMask.
REQ-014 In state ACTIVE, each non-stalled, non-flushed instruction SHALL increment slot and decrement rem, and the state SHALL return to IDLE when rem reaches 0.
REQ-015 In state ACTIVE, PCSrc=1 SHALL force a return to IDLE at the same edge (branch out of the block).
REQ-016 In state ACTIVE, an ItStart SHALL NOT reload the block, SHALL be evaluated as an ordinary slot instruction with its writes suppressed, and SHALL pulse ItErr for one cycle.
REQ-017 Flush SHALL force IDLE with rem=0 and slot=0 at the next edge, and SHALL take priority over Stall and over ItStart.
REQ-018 Stall (without Flush) SHALL freeze Flags, the state, rem and slot.
REQ-019 When PIPE=1, PCSrc, RegWrite, MemWrite, CondEx and ItErr SHALL be registered, giving exactly 1 cycle of latency; Flags and ItActive SHALL always be direct register outputs.
REQ-020 When PIPE=0, the enables SHALL be valid in the same cycle as their inputs.

Reset
REQ-021 On reset=0, asynchronously: Flags=0, state=IDLE, rem=0, slot=0, latched ItCond/ItMask=0, and all outputs=0.
REQ-022 On reset release, the first instruction SHALL evaluate against Flags=0, with no spurious enable for that cycle.
REQ-023 Reset asserted in state ACTIVE SHALL abandon the block; no slot executes after release.

Verification
REQ-024 Flags=0100, Cond=0000, RegW=1 -> RegWrite=1; NoWrite=1 -> RegWrite=0; Cond=0001 -> RegWrite=0.
REQ-025 FlagW=10, ALUFlags=1111, AL -> Flags=1100 next cycle; then FlagW=01 with a failing Cond -> Flags unchanged.
REQ-026 ItStart, ItLen=3, ItMask=0101, ItCond=EQ, Z=1 -> slots execute then/else/then, i.e. RegWrite 1,0,1; ItActive=0 after the third slot.
REQ-027 Block active with a Stall pulse on slot 1 -> slot 1 is held; the block completes one cycle later with the same enable pattern.
REQ-028 Flush in slot 1 -> slot 1 enables=0, ItActive=0 next cycle; the following instruction uses its own Cond.
REQ-029 Nested ItStart in slot 0 -> ItErr pulse, rem not reloaded; PIPE=1 vs PIPE=0 -> identical enable sequences offset by 1 cycle.
